// File: rtl/baud_tick_generator_pkg.sv
// Shared constants and the divisor calculation for the UART baud generator.
package uart_pkg;

  localparam int unsigned CLOCK_RATE_DEF = 66000000;
  localparam int unsigned BAUD_RATE_DEF  = 9600;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DIV_WIDTH_DEF  = 16;
  localparam int unsigned FRAC_BITS_DEF  = 4;

  // Fixed-point oversample period, rounded to nearest: clock*2^frac / (baud*os).
  function automatic longint unsigned calc_div(input longint unsigned clock,
                                               input longint unsigned baud,
                                               input longint unsigned os,
                                               input longint unsigned frac_bits);
    longint unsigned num;
    longint unsigned den;
    num = clock << frac_bits;
    den = baud * os;
    return (2 * num + den) / (2 * den);
  endfunction

  localparam longint unsigned DEF_DIV =
    calc_div(64'(CLOCK_RATE_DEF), 64'(BAUD_RATE_DEF), 64'(OVERSAMPLE_DEF), 64'(FRAC_BITS_DEF));
  localparam int unsigned DEF_DIV_INT  = int'(DEF_DIV >> FRAC_BITS_DEF);
  localparam int unsigned DEF_DIV_FRAC = int'(DEF_DIV % (64'd1 << FRAC_BITS_DEF));
  localparam int unsigned OS_W         = $clog2(OVERSAMPLE_DEF);

endpackage

// File: rtl/baud_tick_generator_if.sv
// Control and tick bundle between the UART datapath (master) and the baud generator (slave).
interface baud_tick_generator_if
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = int'(DIV_WIDTH_DEF),
  parameter int FRAC_BITS = int'(FRAC_BITS_DEF)
) ();

  logic                 en;
  logic [DIV_WIDTH-1:0] div_int;
  logic [FRAC_BITS-1:0] div_frac;
  logic                 div_load;
  logic                 rx_resync;
  logic                 rx_tick;
  logic                 rx_mid;
  logic                 tx_tick;

  modport master (
    output en, div_int, div_frac, div_load, rx_resync,
    input  rx_tick, rx_mid, tx_tick
  );

  modport slave (
    input  en, div_int, div_frac, div_load, rx_resync,
    output rx_tick, rx_mid, tx_tick
  );

endinterface

// File: rtl/baud_tick_generator_phase_chain.sv
// One fractional phase chain: period counter, fractional accumulator and
// oversample index. The period length is latched on its first cycle (cnt==0),
// so a divisor change never alters a period that is already running.
module baud_phase_chain #(
  parameter int DIV_WIDTH = 16,
  parameter int FRAC_BITS = 4,
  parameter int OS_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div_int,
  input  logic [FRAC_BITS-1:0] div_frac,
  output logic                 tc,
  output logic [OS_W-1:0]      os
);

  localparam logic [DIV_WIDTH:0]   PER_ONE = 1;
  localparam logic [DIV_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = 2;
  localparam logic [OS_W-1:0]      OS_ONE  = 1;

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [FRAC_BITS-1:0] acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [DIV_WIDTH:0]   per_q, per_d;
  logic [DIV_WIDTH:0]   per_fresh, per_cur;
  logic [DIV_WIDTH-1:0] int_clamped;
  logic [FRAC_BITS:0]   acc_sum;

  // Terminal-count decode and next-state for counter, accumulator and index.
  always_comb begin
    int_clamped = (div_int < MIN_DIV) ? MIN_DIV : div_int;
    per_fresh   = {1'b0, int_clamped} + {{DIV_WIDTH{1'b0}}, carry_q};
    per_cur     = (cnt_q == '0) ? per_fresh : per_q;
    tc          = en && ({1'b0, cnt_q} == (per_cur - PER_ONE));
    acc_sum     = {1'b0, acc_q} + {1'b0, div_frac};

    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    os_d    = os_q;
    per_d   = per_q;

    if (!en || restart) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      os_d    = '0;
    end else begin
      if (cnt_q == '0) per_d = per_fresh;
      if (tc) begin
        cnt_d            = '0;
        {carry_d, acc_d} = acc_sum;
        os_d             = os_q + OS_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Chain state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      os_q    <= '0;
      per_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      os_q    <= os_d;
      per_q   <= per_d;
    end
  end

  assign os = os_q;

endmodule

// File: rtl/baud_tick_generator.sv
// Fractional baud generator: shadow divisor registers, independent rx and tx
// phase chains, and registered single-cycle tick outputs.
module baud_tick_generator
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 66000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int          DIV_WIDTH  = 16,
  parameter int          FRAC_BITS  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  baud_tick_generator_if.slave bus
);

  localparam int OS_W_L = $clog2(OVERSAMPLE);
  localparam longint unsigned DEF_DIV_L =
    calc_div(64'(CLOCK_RATE), 64'(BAUD_RATE), 64'(OVERSAMPLE), 64'(FRAC_BITS));
  localparam logic [DIV_WIDTH-1:0] DEF_INT  = DIV_WIDTH'(DEF_DIV_L >> FRAC_BITS);
  localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_DIV_L);
  localparam logic [OS_W_L-1:0]    OS_MID   = OS_W_L'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W_L-1:0]    OS_LAST  = OS_W_L'(OVERSAMPLE - 1);

  logic [DIV_WIDTH-1:0] div_int_q, div_int_d;
  logic [FRAC_BITS-1:0] div_frac_q, div_frac_d;
  logic                 rx_tc, tx_tc;
  logic [OS_W_L-1:0]    rx_os, tx_os;
  logic                 rx_tick_q, rx_tick_d;
  logic                 rx_mid_q, rx_mid_d;
  logic                 tx_tick_q, tx_tick_d;

  // Shadow divisor capture on div_load.
  always_comb begin
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    if (bus.div_load) begin
      div_int_d  = bus.div_int;
      div_frac_d = bus.div_frac;
    end
  end

  // Shadow divisor registers; reset to the build-time baud.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int_q  <= DEF_INT;
      div_frac_q <= DEF_FRAC;
    end else begin
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
    end
  end

  baud_phase_chain #(
    .DIV_WIDTH (DIV_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OS_W      (OS_W_L)
  ) u_rx_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .restart  (bus.rx_resync),
    .div_int  (div_int_q),
    .div_frac (div_frac_q),
    .tc       (rx_tc),
    .os       (rx_os)
  );

  baud_phase_chain #(
    .DIV_WIDTH (DIV_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OS_W      (OS_W_L)
  ) u_tx_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .restart  (1'b0),
    .div_int  (div_int_q),
    .div_frac (div_frac_q),
    .tc       (tx_tc),
    .os       (tx_os)
  );

  // Output decode; a resync in a terminal-count cycle swallows that rx tick.
  always_comb begin
    rx_tick_d = rx_tc && !bus.rx_resync;
    rx_mid_d  = rx_tick_d && (rx_os == OS_MID);
    tx_tick_d = tx_tc && (tx_os == OS_LAST);
  end

  // Registered ticks keep every output free of combinational input paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_tick_q <= 1'b0;
      rx_mid_q  <= 1'b0;
      tx_tick_q <= 1'b0;
    end else begin
      rx_tick_q <= rx_tick_d;
      rx_mid_q  <= rx_mid_d;
      tx_tick_q <= tx_tick_d;
    end
  end

  assign bus.rx_tick = rx_tick_q;
  assign bus.rx_mid  = rx_mid_q;
  assign bus.tx_tick = tx_tick_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench: default build (OVERSAMPLE=16) plus a second instance with OVERSAMPLE=4.
module tb_baud_tick_generator;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  baud_tick_generator_if #(.DIV_WIDTH(16), .FRAC_BITS(4)) bus ();
  baud_tick_generator_if #(.DIV_WIDTH(16), .FRAC_BITS(4)) bus4 ();

  baud_tick_generator u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  baud_tick_generator #(.OVERSAMPLE(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return bus.rx_tick;
      1:       return bus.tx_tick;
      default: return bus4.rx_tick;
    endcase
  endfunction

  // Counts negedges until the selected tick is seen or the limit expires.
  task automatic wait_sig(input int w, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(w) !== 1'b1 && n < limit);
  endtask

  task automatic load_div(input logic [15:0] di, input logic [3:0] df);
    bus.div_int  = di;
    bus.div_frac = df;
    bus.div_load = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
  endtask

  initial begin
    int n, t0, ts, ttx, span, n430, bad, cnt;
    rst_n = 1'b0;
    bus.en = 1'b1;  bus.div_int = '0;  bus.div_frac = '0;  bus.div_load = 1'b0;  bus.rx_resync = 1'b0;
    bus4.en = 1'b0; bus4.div_int = '0; bus4.div_frac = '0; bus4.div_load = 1'b0; bus4.rx_resync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_tick", 32'(bus.rx_tick), 0);
    chk("rst_rx_mid",  32'(bus.rx_mid),  0);
    chk("rst_tx_tick", 32'(bus.tx_tick), 0);
    rst_n = 1'b1;
    t0 = cyc;

    // Default divisor 429 + 11/16, running from reset release
    wait_sig(0, 1000, n);
    chk("first_rx_period", n, 429);
    span = 0; n430 = 0; bad = 0;
    for (int k = 2; k <= 17; k++) begin
      wait_sig(0, 1000, n);
      span += n;
      if (n == 430) n430++;
      else if (n != 429) bad++;
      if (k == 8)  chk("rx_mid_tick8", 32'(bus.rx_mid), 1);
      if (k == 15) chk("tx_idle_tick15", 32'(bus.tx_tick), 0);
      if (k == 16) begin
        chk("tx_on_tick16", 32'(bus.tx_tick), 1);
        chk("first_tx_latency", cyc - t0, 6874);
      end
    end
    chk("span_16_periods", span, 6875);
    chk("long_periods", n430, 11);
    chk("bad_periods", bad, 0);

    // Divisor 5: resync on a terminal-count cycle
    load_div(16'd5, 4'd0);
    repeat (3) wait_sig(0, 1000, n);
    wait_sig(1, 8000, n);
    wait_sig(1, 200, n);
    chk("tx_period_div5", n, 80);
    ttx = cyc;
    wait_sig(0, 20, n);
    repeat (4) @(negedge clk);
    bus.rx_resync = 1'b1;
    @(negedge clk);
    bus.rx_resync = 1'b0;
    chk("resync_swallow", 32'(bus.rx_tick), 0);
    wait_sig(0, 20, n);
    chk("resync_next_rx", n, 5);
    for (int k = 2; k <= 8; k++) begin
      wait_sig(0, 20, n);
      if (k == 7) chk("resync_mid_tick7", 32'(bus.rx_mid), 0);
      if (k == 8) chk("resync_mid_tick8", 32'(bus.rx_mid), 1);
    end
    wait_sig(1, 200, n);
    chk("tx_undisturbed", cyc - ttx, 80);

    // Divisor 5.5: alternating periods
    load_div(16'd5, 4'd8);
    repeat (3) wait_sig(0, 20, n);
    ts = cyc; bad = 0;
    for (int k = 0; k < 1000; k++) begin
      wait_sig(0, 20, n);
      if (n != 5 && n != 6) bad++;
    end
    chk("span_1000_ticks", cyc - ts, 5500);
    chk("bad_5p5_periods", bad, 0);

    // Mid-period reload keeps the running period
    load_div(16'd20, 4'd0);
    repeat (3) wait_sig(0, 100, n);
    wait_sig(0, 100, n);
    chk("period_20", n, 20);
    ts = cyc;
    repeat (7) @(negedge clk);
    load_div(16'd10, 4'd0);
    wait_sig(0, 100, n);
    chk("running_period_kept", cyc - ts, 20);
    wait_sig(0, 100, n);
    chk("next_period_10", n, 10);
    load_div(16'd1, 4'd0);
    repeat (3) wait_sig(0, 100, n);
    wait_sig(0, 100, n);
    chk("clamp_period_a", n, 2);
    wait_sig(0, 100, n);
    chk("clamp_period_b", n, 2);

    // Asynchronous reset while a tick is high
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rx_tick", 32'(bus.rx_tick), 0);
    chk("async_rst_rx_mid",  32'(bus.rx_mid),  0);
    chk("async_rst_tx_tick", 32'(bus.tx_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 1000, n);
    chk("shadow_default", n, 429);

    // Enable gating
    @(negedge clk);
    bus.en = 1'b0;
    cnt = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.rx_tick === 1'b1 || bus.tx_tick === 1'b1) cnt++;
    end
    chk("no_ticks_disabled", cnt, 0);
    bus.en = 1'b1;
    t0 = cyc;
    wait_sig(0, 1000, n);
    chk("rx_after_enable", n, 429);
    wait_sig(1, 8000, n);
    chk("tx_after_enable", cyc - t0, 6874);

    // OVERSAMPLE=4 instance, divisor 3
    bus4.div_int  = 16'd3;
    bus4.div_load = 1'b1;
    @(negedge clk);
    bus4.div_load = 1'b0;
    bus4.en       = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      wait_sig(2, 10, n);
      chk("os4_period", n, 3);
      chk("os4_rx_mid",  32'(bus4.rx_mid),  32'((k % 4) == 2));
      chk("os4_tx_tick", 32'(bus4.tx_tick), 32'((k % 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
